// File: rtl/imem_responder_pkg.sv
// Shared types for the instruction-memory responder: word width, NOP encoding,
// fault reasons and the response record carried through the pipeline and FIFO.
package imem_pkg;
  localparam int IMEM_WORD_W = 32;
  localparam logic [IMEM_WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_ALIGN,
    FLT_RANGE,
    FLT_PARITY
  } flt_e;

  typedef struct packed {
    logic [31:0]            addr;
    logic [IMEM_WORD_W-1:0] instr;
    logic                   fault;
  } rsp_t;
endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus preload port between the IF stage (master)
// and the instruction-memory responder (slave).
interface imem_responder_if #(
  parameter int DEPTH_WORDS = 256
);
  import imem_pkg::*;
  localparam int AW = $clog2(DEPTH_WORDS);

  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic                   flush;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IMEM_WORD_W-1:0] rsp_instr;
  logic [31:0]            rsp_addr;
  logic                   rsp_fault;
  logic                   ld_en;
  logic [AW-1:0]          ld_index;
  logic [IMEM_WORD_W-1:0] ld_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, ld_en, ld_index, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, ld_en, ld_index, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );
endinterface

// File: rtl/imem_responder_rsp_fifo.sv
// Response FIFO {addr, instr, fault} with clear and registered count. When empty the
// read port shows the last popped entry so the response outputs hold their values.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  rsp_t                   wdata,
  input  logic                   pop,
  output rsp_t                   rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  rsp_t          mem [DEPTH];
  rsp_t          hold;
  logic [PW-1:0] wptr, rptr;
  logic          nempty, do_pop;

  assign nempty = (count != '0);
  assign do_pop = pop & nempty;
  assign rdata  = nempty ? mem[rptr] : hold;

  always_ff @(posedge clock) begin
    if (push & ~clear) mem[wptr] <= wdata;
  end

  // A pop that lands on a clear is still consumed, so hold tracks it either way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      hold  <= '0;
    end else begin
      if (do_pop) hold <= mem[rptr];
      if (clear) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push)   wptr <= wptr + 1'b1;
        if (do_pop) rptr <= rptr + 1'b1;
        count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
      end
    end
  end
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: address check, LATENCY-stage read pipeline, credit-limited
// in-order response FIFO. Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'd32,
  parameter int          LATENCY     = 2,
  parameter int          FIFO_DEPTH  = 4
) (
  input logic              clock,
  input logic              reset_n,
  imem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [IMEM_WORD_W-1:0] mem [DEPTH_WORDS];
  logic [31:0]            word_off;
  logic [AW-1:0]          rd_idx;
  logic                   par_bad;
  flt_e                   flt;
  rsp_t                   s0;
  rsp_t                   stg [1:LATENCY];
  logic [LATENCY:1]       vld_pipe;
  logic [CW-1:0]          cred, fifo_cnt;
  logic                   live, accept, pop, push;
  rsp_t                   fifo_head;

  assign word_off = (bus.req_addr - BASE_ADDR) >> 2;
  assign rd_idx   = word_off[AW-1:0];

  always_ff @(posedge clock) begin
    if (bus.ld_en) mem[bus.ld_index] <= bus.ld_data;
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (bus.ld_en) par_mem[bus.ld_index] <= ^bus.ld_data;
  end

  assign par_bad = (^mem[rd_idx]) != par_mem[rd_idx];
`else
  assign par_bad = 1'b0;
`endif

  // Array read is combinational off the request; the stored word is the pre-write value.
  always_comb begin
    flt = FLT_NONE;
    if (bus.req_addr[1:0] != 2'b00)                                       flt = FLT_ALIGN;
    else if (bus.req_addr < BASE_ADDR || word_off >= 32'(DEPTH_WORDS))    flt = FLT_RANGE;
    else if (par_bad)                                                     flt = FLT_PARITY;
    s0.addr  = bus.req_addr;
    s0.fault = (flt != FLT_NONE);
    s0.instr = s0.fault ? NOP_INSTR : mem[rd_idx];
  end

  always_ff @(posedge clock) begin
    stg[1] <= s0;
    for (int k = 2; k <= LATENCY; k++) stg[k] <= stg[k-1];
  end

  // Credits count everything accepted but not yet popped, so the FIFO never overflows.
  assign bus.req_ready = live & ~bus.flush & (cred < CW'(FIFO_DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign push          = vld_pipe[LATENCY] & ~bus.flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live     <= 1'b0;
      vld_pipe <= '0;
      cred     <= '0;
    end else begin
      live <= 1'b1;
      if (bus.flush) begin
        vld_pipe <= '0;
        cred     <= '0;
      end else begin
        vld_pipe[1] <= accept;
        for (int k = 2; k <= LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
        cred <= cred + CW'(accept) - CW'(pop);
      end
    end
  end

  imem_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (bus.flush),
    .push    (push),
    .wdata   (stg[LATENCY]),
    .pop     (pop),
    .rdata   (fifo_head),
    .count   (fifo_cnt)
  );

  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_addr  = fifo_head.addr;
  assign bus.rsp_instr = fifo_head.instr;
  assign bus.rsp_fault = fifo_head.fault;
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed steps plus a random phase, every cycle checked
// against a queue-based model of accepted fetches and a shadow copy of the memory.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int          DEPTH_WORDS = 256;
  localparam int          LATENCY     = 2;
  localparam int          FIFO_DEPTH  = 4;
  localparam logic [31:0] BASE_ADDR   = 32'd32;
  localparam int          AW          = $clog2(DEPTH_WORDS);

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  imem_responder_if #(.DEPTH_WORDS(DEPTH_WORDS)) bus ();

  imem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .BASE_ADDR   (BASE_ADDR),
    .LATENCY     (LATENCY),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  logic [31:0] mem_m [DEPTH_WORDS];
  bit          par_bad_m [DEPTH_WORDS];
  int          cyc, checks, errors, pops;
  bit          live, t_acc, t_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] a);
    exp_t   e;
    longint off;
    off      = (longint'(a) - longint'(BASE_ADDR)) / 4;
    e.addr   = a;
    e.acc    = cyc;
    e.fault  = (a % 4 != 0) || (longint'(a) < longint'(BASE_ADDR)) || (off >= DEPTH_WORDS);
    if (!e.fault && par_bad_m[int'(off)]) e.fault = 1'b1;
    e.instr  = e.fault ? 32'h0 : mem_m[int'(off)];
    return e;
  endfunction

  // One clock: sample and check outputs mid-cycle, then advance the model past the edge.
  task automatic tick();
    bit   exp_rdy, exp_vld;
    exp_t e, ne;
    #1;
    exp_rdy = live && !bus.flush && (q.size() < FIFO_DEPTH);
    exp_vld = (q.size() > 0) && (q[0].acc + LATENCY + 1 <= cyc);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_vld));
    e = exp_vld ? q[0] : last;
    chk("rsp_addr",  bus.rsp_addr, e.addr);
    chk("rsp_instr", bus.rsp_instr, e.instr);
    chk("rsp_fault", 32'(bus.rsp_fault), 32'(e.fault));
    t_acc = bus.req_valid && bus.req_ready;
    t_pop = bus.rsp_valid && bus.rsp_ready;
    ne = predict(bus.req_addr);
    @(posedge clock);
    #1;
    pops += int'(t_pop);
    if (exp_vld && bus.rsp_ready) last = q.pop_front();
    if (bus.flush) q.delete();
    else if (bus.req_valid && exp_rdy) q.push_back(ne);
    if (bus.ld_en) begin
      mem_m[bus.ld_index]     = bus.ld_data;
      par_bad_m[bus.ld_index] = 1'b0;
    end
    live = 1'b1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] a);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    do begin
      tick();
      n++;
    end while (!t_acc && n < 20);
    chk("send_accept", 32'(t_acc), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;
    while (q.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, nacc, r;
    logic [31:0] a;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_index  = '0;
    bus.ld_data   = '0;
    cyc = 0; checks = 0; errors = 0; pops = 0; live = 1'b0;
    last = '{default: 0};
    for (int i = 0; i < DEPTH_WORDS; i++) par_bad_m[i] = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_addr",  bus.rsp_addr, 32'd0);
    chk("reset_rsp_instr", bus.rsp_instr, 32'd0);
    chk("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH_WORDS; i++) begin
      bus.ld_en    = 1'b1;
      bus.ld_index = AW'(i);
      bus.ld_data  = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
      tick();
    end
    bus.ld_en = 1'b0;

    // back-to-back fetches, exact latency checked by the model
    bus.rsp_ready = 1'b1;
    p0 = pops;
    send(32); send(36); send(40);
    drain();
    chk("t1_rsp_count", pops - p0, 32'd3);

    // credit limit with consumer stalled
    bus.rsp_ready = 1'b0;
    p0 = pops; nacc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'd44 + 32'(4 * nacc);
      tick();
      nacc += int'(t_acc);
    end
    chk("t2_accepted", nacc, 32'd4);
    chk("t2_ready_low", 32'(bus.req_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    send(32'd60); send(32'd64);
    drain();
    chk("t2_rsp_count", pops - p0, 32'd6);

    // fault cases
    send(34); send(28); send(32 + 4 * 256);
    drain();

    // flush with requests in flight
    bus.rsp_ready = 1'b0;
    send(44); send(48); send(52);
    bus.req_addr = 32'd56;
    bus.flush    = 1'b1;
    tick();
    chk("t4_flush_noaccept", 32'(t_acc), 32'd0);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    p0 = pops;
    send(60);
    drain();
    chk("t4_one_rsp", pops - p0, 32'd1);

    // preload write colliding with a fetch of the same word
    bus.ld_en    = 1'b1;
    bus.ld_index = AW'(2);
    bus.ld_data  = 32'hAAAA_5555;
    send(40);
    bus.ld_en = 1'b0;
    send(40);
    drain();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      a = 32'd32 + 32'(4 * $urandom_range(0, 255));
      else if (r < 88) a = 32'd32 + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
      else if (r < 94) a = 32'(4 * $urandom_range(0, 7));
      else             a = 32'd32 + 32'd1024 + 32'(4 * $urandom_range(0, 1000));
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_addr  = a;
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.ld_en     = ($urandom_range(0, 9) == 0);
      bus.ld_index  = AW'($urandom);
      bus.ld_data   = $urandom;
      tick();
    end
    bus.ld_en = 1'b0;
    drain();

`ifdef IMEM_PARITY_EN
    dut.par_mem[1] = ~dut.par_mem[1];
    par_bad_m[1]   = 1'b1;
    send(36);
    drain();
`endif

    // reset in the middle of traffic
    bus.rsp_ready = 1'b0;
    send(44); send(48); send(52);
    bus.req_valid = 1'b0;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_rsp_addr",  bus.rsp_addr, 32'd0);
    chk("midrst_rsp_instr", bus.rsp_instr, 32'd0);
    q.delete();
    last = '{default: 0};
    live = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    tick();
    send(32);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
